// File: rtl/wbh_clk_switch_seq_if.sv
// ---------------------------------------------------------------------------
// wbh_clk_switch_seq_if
//
// Register-bus write channel between the clock-switch sequencer and the wbh
// register block. The sequencer is the only bus master; it issues a single
// write to register 0, byte lane 2.
//
// Signals:
//   reg_cs    : chip select, held for the whole write
//   reg_wr    : write strobe, always equal to reg_cs for this master
//   reg_addr  : register address (3 bits)
//   reg_wdata : write data (32 bits)
//   reg_be    : byte enables (4 bits)
//   reg_ack   : acknowledge from the register block
//
// Modports:
//   master : sequencer side (drives strobes/addr/data, samples ack)
//   slave  : register-block side
// ---------------------------------------------------------------------------
interface wbh_clk_switch_seq_if;
  logic        reg_cs;
  logic        reg_wr;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic        reg_ack;

  modport master (
    output reg_cs,
    output reg_wr,
    output reg_addr,
    output reg_wdata,
    output reg_be,
    input  reg_ack
  );

  modport slave (
    input  reg_cs,
    input  reg_wr,
    input  reg_addr,
    input  reg_wdata,
    input  reg_be,
    output reg_ack
  );
endinterface

// File: rtl/wbh_clk_switch_seq.sv
// ---------------------------------------------------------------------------
// wbh_clk_switch_seq
//
// Glitch-safe runtime change of the wbh clock-control byte (WB src/ratio in
// [3:0], CPU src/ratio in [7:4]). A change request gates the clocks, writes
// the new byte to register 0 / byte lane 2, waits for dividers and muxes to
// settle, then ungates. Requesting the value already in force completes
// immediately without touching the clock gate.
//
// Parameters:
//   GATE_WAIT      : cycles clk_enb is low before the write (1..255)
//   SETTLE_WAIT    : cycles after the write ack before ungating (1..255)
//   TIMEOUT        : max cycles to wait for reg_ack (timeout build only)
//   RESET_CLK_CTRL : reset value of cur_clk_ctrl (must match strap default)
//
// Ports:
//   mclk         in  : single clock for all logic
//   reset        in  : synchronous, active-high reset
//   sw_req       in  : change request, sampled only while idle and not busy
//   sw_clk_ctrl  in  : requested control byte
//   sw_busy      out : sequence in progress (also high in the no-op cycle)
//   sw_done      out : one-cycle pulse when a sequence completes
//   sw_err       out : one-cycle pulse on ack timeout (0 without the feature)
//   cur_clk_ctrl out : last successfully committed control byte
//   clk_enb      out : clock-gate enable towards the register block
//   reg_bus      if  : register-bus write channel (master modport)
//
// Build option:
//   WBH_CLKSW_TIMEOUT_EN : when defined, a write that sees no ack within
//                          TIMEOUT cycles is abandoned, sw_err pulses, the
//                          committed byte is kept and the clocks are ungated
//                          through the normal settle phase. When undefined,
//                          the write waits for ack indefinitely and sw_err
//                          is tied low.
// ---------------------------------------------------------------------------
module wbh_clk_switch_seq #(
  parameter int         GATE_WAIT      = 8,
  parameter int         SETTLE_WAIT    = 16,
  parameter int         TIMEOUT        = 64,
  parameter logic [7:0] RESET_CLK_CTRL = 8'h00
) (
  input  logic                        mclk,
  input  logic                        reset,
  input  logic                        sw_req,
  input  logic [7:0]                  sw_clk_ctrl,
  output logic                        sw_busy,
  output logic                        sw_done,
  output logic                        sw_err,
  output logic [7:0]                  cur_clk_ctrl,
  output logic                        clk_enb,
  wbh_clk_switch_seq_if.master        reg_bus
);

  // Counter reload values; counters run load..0, so a load of N-1 gives
  // exactly N cycles in the state.
  localparam logic [7:0] GATE_LOAD   = 8'(GATE_WAIT - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_WAIT - 1);

  // Fixed write target: register 0, byte lane 2.
  localparam logic [2:0] CTRL_ADDR = 3'd0;
  localparam logic [3:0] CTRL_BE   = 4'b0100;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    WRITE,
    SETTLE
  } state_t;

  state_t      state;
  logic [7:0]  cnt;        // shared gate/settle down-counter
  logic        req_pend;   // request latched, compare happens next cycle
  logic [7:0]  new_ctrl;   // byte being committed by the current sequence
  logic        busy_q;
  logic        done_q;
  logic        enb_q;
  logic        cs_q;
  logic [7:0]  cur_q;
  logic [31:0] wdata_q;

`ifdef WBH_CLKSW_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT - 1);

  logic [7:0]  to_cnt;     // cycles left to wait for reg_ack
  logic        err_q;
`endif

  // NOTE: every register below is assigned with <= only, so all branches
  // read the pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      req_pend <= 1'b0;
      new_ctrl <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enb_q    <= 1'b1;
      cs_q     <= 1'b0;
      cur_q    <= RESET_CLK_CTRL;
      wdata_q  <= '0;
`ifdef WBH_CLKSW_TIMEOUT_EN
      to_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      done_q <= 1'b0;
`ifdef WBH_CLKSW_TIMEOUT_EN
      err_q  <= 1'b0;
`endif

      case (state)
        IDLE: begin
          enb_q <= 1'b1;
          cs_q  <= 1'b0;
          if (req_pend) begin
            // Second cycle of acceptance: decide between no-op and a real
            // sequence. busy is raised here in both cases.
            req_pend <= 1'b0;
            busy_q   <= 1'b1;
            if (new_ctrl == cur_q) begin
              done_q <= 1'b1;
            end else begin
              state <= GATE;
              enb_q <= 1'b0;
              cnt   <= GATE_LOAD;
            end
          end else begin
            busy_q <= 1'b0;
            // busy_q still high here means we are in the no-op cycle, during
            // which requests are dropped like any other busy cycle.
            if (sw_req && !busy_q) begin
              new_ctrl <= sw_clk_ctrl;
              req_pend <= 1'b1;
            end
          end
        end

        GATE: begin
          if (cnt == '0) begin
            state   <= WRITE;
            cs_q    <= 1'b1;
            wdata_q <= {8'h00, new_ctrl, 16'h0000};
`ifdef WBH_CLKSW_TIMEOUT_EN
            to_cnt  <= TIMEOUT_LOAD;
`endif
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        WRITE: begin
          // cs stays asserted with constant data until ack; a slave that
          // performs the write every cycle just rewrites the same byte.
          if (reg_bus.reg_ack) begin
            state <= SETTLE;
            cs_q  <= 1'b0;
            cur_q <= new_ctrl;
            cnt   <= SETTLE_LOAD;
          end
`ifdef WBH_CLKSW_TIMEOUT_EN
          else if (to_cnt == '0) begin
            // Abandon the write; the old byte stays committed, but the
            // clocks still go through a full settle before ungating.
            state <= SETTLE;
            cs_q  <= 1'b0;
            err_q <= 1'b1;
            cnt   <= SETTLE_LOAD;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
`endif
        end

        SETTLE: begin
          if (cnt == '0) begin
            state  <= IDLE;
            enb_q  <= 1'b1;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state  <= IDLE;
          enb_q  <= 1'b1;
          cs_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs: all driven straight from registers or constants.
  assign sw_busy      = busy_q;
  assign sw_done      = done_q;
  assign cur_clk_ctrl = cur_q;
  assign clk_enb      = enb_q;

`ifdef WBH_CLKSW_TIMEOUT_EN
  assign sw_err = err_q;
`else
  assign sw_err = 1'b0;
`endif

  assign reg_bus.reg_cs    = cs_q;
  assign reg_bus.reg_wr    = cs_q;
  assign reg_bus.reg_addr  = CTRL_ADDR;
  assign reg_bus.reg_be    = CTRL_BE;
  assign reg_bus.reg_wdata = wdata_q;

endmodule

// File: tb/tb_wbh_clk_switch_seq.sv
// ---------------------------------------------------------------------------
// tb_wbh_clk_switch_seq
//
// Directed bench for wbh_clk_switch_seq with default parameters. A small
// register-block model acks one cycle after reg_cs rises. Cycle numbers
// below count from the edge that samples sw_req (edge 0); outputs of cycle
// c are sampled at the falling edge following edge c.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wbh_clk_switch_seq;

  logic       mclk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_req = 1'b0;
  logic [7:0] sw_clk_ctrl = 8'h00;
  logic       sw_busy;
  logic       sw_done;
  logic       sw_err;
  logic [7:0] cur_clk_ctrl;
  logic       clk_enb;

  wbh_clk_switch_seq_if bus ();

  wbh_clk_switch_seq dut (
    .mclk         (mclk),
    .reset        (reset),
    .sw_req       (sw_req),
    .sw_clk_ctrl  (sw_clk_ctrl),
    .sw_busy      (sw_busy),
    .sw_done      (sw_done),
    .sw_err       (sw_err),
    .cur_clk_ctrl (cur_clk_ctrl),
    .clk_enb      (clk_enb),
    .reg_bus      (bus)
  );

  always #5 mclk = ~mclk;

  int errors = 0;
  int checks = 0;
  int err_total = 0;

  // Register-block model: ack high for the cycle after cs is first seen.
  bit ack_en = 1'b1;
  bit prev_cs = 1'b0;
  bit nack;
  initial bus.reg_ack = 1'b0;
  always @(posedge mclk) begin
    #1;
    nack = ack_en && prev_cs && !bus.reg_ack;
    prev_cs = bus.reg_cs;
    bus.reg_ack = nack;
  end

  always @(negedge mclk) if (sw_err === 1'b1) err_total++;

  // Present a request for one edge; returns at the sample point of cycle 0.
  task automatic issue(input logic [7:0] val);
    @(negedge mclk);
    sw_req = 1'b1;
    sw_clk_ctrl = val;
    @(negedge mclk);
    sw_req = 1'b0;
  endtask

  task automatic test_reset();
    int cs_seen = 0;
    int enb_low = 0;
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    checks++; if (clk_enb !== 1'b1) begin errors++; $display("FAIL reset_clk_enb: got %b expected 1", clk_enb); end
    checks++; if (bus.reg_cs !== 1'b0 || bus.reg_wr !== 1'b0) begin errors++; $display("FAIL reset_strobes: got cs=%b wr=%b expected 0 0", bus.reg_cs, bus.reg_wr); end
    checks++; if (cur_clk_ctrl !== 8'h00) begin errors++; $display("FAIL reset_cur: got %h expected 00", cur_clk_ctrl); end
    checks++; if ({sw_busy, sw_done, sw_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/err=%b expected 000", {sw_busy, sw_done, sw_err}); end
    checks++; if (bus.reg_wdata !== 32'h0 || bus.reg_be !== 4'b0100 || bus.reg_addr !== 3'd0) begin
      errors++; $display("FAIL reset_bus_consts: got wdata=%h be=%b addr=%0d expected 00000000 0100 0", bus.reg_wdata, bus.reg_be, bus.reg_addr);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (bus.reg_cs !== 1'b0) cs_seen++;
      if (clk_enb !== 1'b1) enb_low++;
    end
    checks++; if (cs_seen != 0 || enb_low != 0) begin errors++; $display("FAIL idle_quiet: got cs_cycles=%0d enb_low=%0d expected 0 0", cs_seen, enb_low); end
  endtask

  task automatic test_change();
    logic e_enb, e_cs, e_done, e_busy;
    issue(8'h5A);
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) @(negedge mclk);
      e_enb  = !(c >= 1 && c <= 26);
      e_cs   = (c == 9 || c == 10);
      e_done = (c == 27);
      e_busy = (c >= 1 && c <= 26);
      checks++; if ({clk_enb, bus.reg_cs, sw_done, sw_busy} !== {e_enb, e_cs, e_done, e_busy}) begin
        errors++; $display("FAIL change_c%0d: got enb/cs/done/busy=%b expected %b", c,
                           {clk_enb, bus.reg_cs, sw_done, sw_busy}, {e_enb, e_cs, e_done, e_busy});
      end
      if (e_cs) begin
        checks++; if (bus.reg_wdata !== 32'h005A0000 || bus.reg_be !== 4'b0100 || bus.reg_wr !== 1'b1 || bus.reg_addr !== 3'd0) begin
          errors++; $display("FAIL change_write_c%0d: got wdata=%h be=%b wr=%b addr=%0d expected 005a0000 0100 1 0", c,
                             bus.reg_wdata, bus.reg_be, bus.reg_wr, bus.reg_addr);
        end
      end
      if (c == 10) begin
        checks++; if (cur_clk_ctrl !== 8'h00) begin errors++; $display("FAIL change_cur_early: got %h expected 00", cur_clk_ctrl); end
      end
    end
    checks++; if (cur_clk_ctrl !== 8'h5A) begin errors++; $display("FAIL change_cur: got %h expected 5a", cur_clk_ctrl); end
  endtask

  task automatic test_noop();
    logic e_done;
    issue(8'h5A);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge mclk);
      e_done = (c == 1);
      checks++; if ({clk_enb, bus.reg_cs, sw_done, sw_busy} !== {1'b1, 1'b0, e_done, e_done}) begin
        errors++; $display("FAIL noop_c%0d: got enb/cs/done/busy=%b expected %b", c,
                           {clk_enb, bus.reg_cs, sw_done, sw_busy}, {1'b1, 1'b0, e_done, e_done});
      end
    end
    checks++; if (cur_clk_ctrl !== 8'h5A) begin errors++; $display("FAIL noop_cur: got %h expected 5a", cur_clk_ctrl); end
  endtask

  task automatic test_reset_mid();
    int cs_seen = 0;
    int enb_low = 0;
    issue(8'hC3);
    for (int c = 1; c <= 12; c++) @(negedge mclk);
    reset = 1'b1;
    @(negedge mclk);
    checks++; if ({clk_enb, bus.reg_cs, bus.reg_wr, sw_busy} !== 4'b1000) begin
      errors++; $display("FAIL midreset_out: got enb/cs/wr/busy=%b expected 1000", {clk_enb, bus.reg_cs, bus.reg_wr, sw_busy});
    end
    checks++; if (cur_clk_ctrl !== 8'h00) begin errors++; $display("FAIL midreset_cur: got %h expected 00", cur_clk_ctrl); end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge mclk);
      if (bus.reg_cs !== 1'b0) cs_seen++;
      if (clk_enb !== 1'b1) enb_low++;
    end
    checks++; if (cs_seen != 0 || enb_low != 0) begin errors++; $display("FAIL midreset_quiet: got cs_cycles=%0d enb_low=%0d expected 0 0", cs_seen, enb_low); end
  endtask

  task automatic test_busy_drop();
    int dones = 0;
    int cs_seen = 0;
    int done_at = -1;
    issue(8'h5A);
    for (int c = 1; c <= 40; c++) begin
      @(negedge mclk);
      if (c == 5) begin sw_req = 1'b1; sw_clk_ctrl = 8'h33; end
      if (c == 6) sw_req = 1'b0;
      if (sw_done === 1'b1) begin dones++; done_at = c; end
      if (bus.reg_cs === 1'b1) cs_seen++;
    end
    checks++; if (dones != 1 || done_at != 27) begin errors++; $display("FAIL busy_drop_done: got count=%0d at=%0d expected 1 27", dones, done_at); end
    checks++; if (cs_seen != 2) begin errors++; $display("FAIL busy_drop_cs: got %0d cs cycles expected 2", cs_seen); end
    checks++; if (cur_clk_ctrl !== 8'h5A) begin errors++; $display("FAIL busy_drop_cur: got %h expected 5a", cur_clk_ctrl); end
  endtask

`ifdef WBH_CLKSW_TIMEOUT_EN
  task automatic test_timeout();
    int cs_seen = 0;
    int errs = 0;
    int err_at = -1;
    int done_at = -1;
    int enb_at = -1;
    ack_en = 1'b0;
    issue(8'h77);
    for (int c = 1; c <= 100; c++) begin
      @(negedge mclk);
      if (bus.reg_cs === 1'b1) cs_seen++;
      if (sw_err === 1'b1) begin errs++; err_at = c; end
      if (sw_done === 1'b1 && done_at < 0) done_at = c;
      if (clk_enb === 1'b1 && enb_at < 0) enb_at = c;
    end
    ack_en = 1'b1;
    checks++; if (cs_seen != 64) begin errors++; $display("FAIL timeout_cs: got %0d cs cycles expected 64", cs_seen); end
    checks++; if (errs != 1 || err_at != 73) begin errors++; $display("FAIL timeout_err: got count=%0d at=%0d expected 1 73", errs, err_at); end
    checks++; if (done_at != 89 || enb_at != 89) begin errors++; $display("FAIL timeout_end: got done_at=%0d enb_at=%0d expected 89 89", done_at, enb_at); end
    checks++; if (cur_clk_ctrl !== 8'h5A) begin errors++; $display("FAIL timeout_cur: got %h expected 5a", cur_clk_ctrl); end
  endtask
`endif

  task automatic test_err_count();
    int exp_err;
`ifdef WBH_CLKSW_TIMEOUT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    checks++; if (err_total != exp_err) begin errors++; $display("FAIL err_pulses: got %0d expected %0d", err_total, exp_err); end
  endtask

  initial begin
    test_reset();
    test_change();
    test_noop();
    test_reset_mid();
    test_busy_drop();
`ifdef WBH_CLKSW_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge mclk);
    test_err_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
